// File: rtl/nes_joy_port_pkg.sv
// Shared constants for the NES controller port pair: NES serial bit order,
// Sega 6-button vector layout and the default turbo divider.
package nes_joy_port_pkg;

  // NES serial byte order, bit0 is shifted out first
  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  // Sega 6-button vector layout (active-low at the port)
  localparam int SG_B     = 0;
  localparam int SG_A     = 1;
  localparam int SG_C     = 2;
  localparam int SG_START = 3;
  localparam int SG_U     = 4;
  localparam int SG_D     = 5;
  localparam int SG_L     = 6;
  localparam int SG_R     = 7;
  localparam int SG_MODE  = 8;
  localparam int SG_X     = 9;
  localparam int SG_Y     = 10;
  localparam int SG_Z     = 11;

  localparam int JOY_W = 12;

  // About 15 Hz turbo at a 25 MHz system clock
  localparam int TURBO_DIV_DEFAULT = 833333;

endpackage

// File: rtl/nes_joy_shift.sv
// One NES controller: maps a Sega vector to the NES byte, detects the end of
// each CPU read and serves the byte through an 8-bit right-shift register.
module nes_joy_shift
  import nes_joy_port_pkg::*;
#(
  parameter bit DPAD_MASK = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [JOY_W-1:0] joy_i,
  input  logic             phase_i,
  input  logic             load_i,
  input  logic             rd_i,
  output logic             q_o
);

  logic [JOY_W-1:0] pressed;
  logic [7:0]       nes_byte;
  logic             up, down, left, right;
  logic             rd_q;
  logic             rd_fall;
  logic [7:0]       sreg_q, sreg_d;
  logic             unused_z;

  // Port vector is active-low; everything downstream is active-high
  assign pressed  = ~joy_i;
  assign unused_z = pressed[SG_Z];

  // Build the NES byte: turbo ORs X/Y into A/B, opposing directions cancel
  always_comb begin
    up    = pressed[SG_U];
    down  = pressed[SG_D];
    left  = pressed[SG_L];
    right = pressed[SG_R];
    if (DPAD_MASK && up && down) begin
      up   = 1'b0;
      down = 1'b0;
    end
    if (DPAD_MASK && left && right) begin
      left  = 1'b0;
      right = 1'b0;
    end
    nes_byte             = 8'h00;
    nes_byte[NES_A]      = pressed[SG_A] | (pressed[SG_X] & phase_i);
    nes_byte[NES_B]      = pressed[SG_B] | (pressed[SG_Y] & phase_i);
    nes_byte[NES_SELECT] = pressed[SG_C] | pressed[SG_MODE];
    nes_byte[NES_START]  = pressed[SG_START];
    nes_byte[NES_UP]     = up;
    nes_byte[NES_DOWN]   = down;
    nes_byte[NES_LEFT]   = left;
    nes_byte[NES_RIGHT]  = right;
  end

  // A read access ends when the registered level drops; shift only then,
  // so the bit stays stable for the whole access
  assign rd_fall = rd_q & ~rd_i;

  // Load wins over shift; shifting fills with 1 so extra reads return 1
  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = nes_byte;
    end else if (rd_fall) begin
      sreg_d = {1'b1, sreg_q[7:1]};
    end
  end

  // Read-level history and shift register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q   <= 1'b0;
      sreg_q <= 8'h00;
    end else begin
      rd_q   <= rd_i;
      sreg_q <= sreg_d;
    end
  end

  assign q_o = sreg_q[0];

endmodule

// File: rtl/nes_joy_port.sv
// NES $4016/$4017 controller port pair for the Dendy core. Holds the strobe
// latch and the shared turbo clock; each player lives in nes_joy_shift.
module nes_joy_port
  import nes_joy_port_pkg::*;
#(
  parameter int TURBO_DIV = TURBO_DIV_DEFAULT,
  parameter bit DPAD_MASK = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [JOY_W-1:0] joy1,
  input  logic [JOY_W-1:0] joy2,
  input  logic             wr4016,
  input  logic             din0,
  input  logic             rd4016,
  input  logic             rd4017,
  output logic             q1,
  output logic             q2
);

  localparam int                CNT_W   = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TURBO_DIV - 1);

  logic             strobe_q, strobe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             load;

  // Strobe follows din0 on every $4016 write
  always_comb begin
    strobe_d = strobe_q;
    if (wr4016) begin
      strobe_d = din0;
    end
  end

  // The write cycle itself loads too, so clearing strobe latches the
  // byte mapped in that same cycle
  assign load = strobe_q | wr4016;

  // Free-running turbo divider; phase flips at each wrap
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Strobe and turbo state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  nes_joy_shift #(
    .DPAD_MASK(DPAD_MASK)
  ) u_port1 (
    .clock  (clock),
    .reset_n(reset_n),
    .joy_i  (joy1),
    .phase_i(phase_q),
    .load_i (load),
    .rd_i   (rd4016),
    .q_o    (q1)
  );

  nes_joy_shift #(
    .DPAD_MASK(DPAD_MASK)
  ) u_port2 (
    .clock  (clock),
    .reset_n(reset_n),
    .joy_i  (joy2),
    .phase_i(phase_q),
    .load_i (load),
    .rd_i   (rd4017),
    .q_o    (q2)
  );

endmodule

// File: tb/tb_nes_joy_port.sv
// Scoreboard bench for nes_joy_port. Two instances share all inputs: one with
// D-pad masking, one without. Stimulus pushes the expected bit for each read
// access; a negedge monitor pops and compares whenever a read is active.
module tb_nes_joy_port;

  logic        clock;
  logic        reset_n;
  logic [11:0] joy1, joy2;
  logic        wr4016, din0, rd4016, rd4017;
  logic        q1, q2, q1_nm, q2_nm;

  int checks = 0;
  int errors = 0;
  int edges;

  typedef struct {
    logic  exp;
    logic  exp_alt;
    string name;
  } exp_t;

  exp_t q16[$];
  exp_t q17[$];

  nes_joy_port #(.TURBO_DIV(4), .DPAD_MASK(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .joy1(joy1), .joy2(joy2),
    .wr4016(wr4016), .din0(din0), .rd4016(rd4016), .rd4017(rd4017),
    .q1(q1), .q2(q2)
  );

  nes_joy_port #(.TURBO_DIV(4), .DPAD_MASK(1'b0)) dut_nm (
    .clock(clock), .reset_n(reset_n), .joy1(joy1), .joy2(joy2),
    .wr4016(wr4016), .din0(din0), .rd4016(rd4016), .rd4017(rd4017),
    .q1(q1_nm), .q2(q2_nm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Clock edges since reset release, used to predict turbo phase
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  function automatic void check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  // Monitor: every cycle a read is active, the port presents a bit
  always @(negedge clock) begin
    exp_t e;
    if (rd4016) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd4016: got q1=%b expected no read", q1);
      end else begin
        e = q16.pop_front();
        check({e.name, "_q1"}, q1, e.exp);
        check({e.name, "_q1_nomask"}, q1_nm, e.exp_alt);
      end
    end
    if (rd4017) begin
      if (q17.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd4017: got q2=%b expected no read", q2);
      end else begin
        e = q17.pop_front();
        check({e.name, "_q2"}, q2, e.exp);
        check({e.name, "_q2_nomask"}, q2_nm, e.exp_alt);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push16(input logic exp, input logic alt, input string name);
    exp_t e;
    e.exp = exp; e.exp_alt = alt; e.name = name;
    q16.push_back(e);
  endtask

  task automatic push17(input logic exp, input logic alt, input string name);
    exp_t e;
    e.exp = exp; e.exp_alt = alt; e.name = name;
    q17.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr4016 = 1'b0; din0 = 1'b0; rd4016 = 1'b0; rd4017 = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Write 1 then 0 to $4016
  task automatic strobe_pulse();
    wr4016 = 1'b1; din0 = 1'b1;
    tick();
    din0 = 1'b0;
    tick();
    wr4016 = 1'b0;
  endtask

  task automatic read16(input logic exp, input logic alt, input string name);
    push16(exp, alt, name);
    rd4016 = 1'b1;
    tick();
    rd4016 = 1'b0;
    tick();
  endtask

  task automatic read17(input logic exp, input logic alt, input string name);
    push17(exp, alt, name);
    rd4017 = 1'b1;
    tick();
    rd4017 = 1'b0;
    tick();
  endtask

  task automatic read_both(input logic e1, input logic e2, input string name);
    push16(e1, e1, name);
    push17(e2, e2, name);
    rd4016 = 1'b1; rd4017 = 1'b1;
    tick();
    rd4016 = 1'b0; rd4017 = 1'b0;
    tick();
  endtask

  // n reads of one port; bits beyond the 8th are the shifted-in 1s
  task automatic seq16(input logic [7:0] b, input logic [7:0] b_alt, input int n, input string name);
    for (int i = 0; i < n; i++)
      read16((i < 8) ? b[i] : 1'b1, (i < 8) ? b_alt[i] : 1'b1, $sformatf("%s[%0d]", name, i));
  endtask

  task automatic seq17(input logic [7:0] b, input logic [7:0] b_alt, input int n, input string name);
    for (int i = 0; i < n; i++)
      read17((i < 8) ? b[i] : 1'b1, (i < 8) ? b_alt[i] : 1'b1, $sformatf("%s[%0d]", name, i));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b1, b2;
    reset_n = 1'b0;
    joy1 = 12'hFFF; joy2 = 12'hFFF;
    wr4016 = 1'b0; din0 = 1'b0; rd4016 = 1'b0; rd4017 = 1'b0;
    do_reset();

    // Reset contents are 00: eight zeros, then fill ones
    seq16(8'h00, 8'h00, 9, "reset16");
    seq17(8'h00, 8'h00, 9, "reset17");

    // Sega B -> NES B (0x02); Sega A -> NES A (0x01)
    joy1 = 12'hFFE;
    strobe_pulse();
    seq16(8'h02, 8'h02, 10, "segaB");
    joy1 = 12'hFFD;
    strobe_pulse();
    seq16(8'h01, 8'h01, 10, "segaA");

    // C + Start -> Select + Start (0x0C)
    joy1 = 12'hFF3;
    strobe_pulse();
    seq16(8'h0C, 8'h0C, 8, "cstart");

    // U+D: masked 0x00, unmasked 0x30
    joy2 = 12'hFCF;
    strobe_pulse();
    seq17(8'h00, 8'h30, 8, "updown");

    // Mode + L+R: masked 0x04, unmasked 0xC4
    joy2 = 12'hE3F;
    strobe_pulse();
    seq17(8'h04, 8'hC4, 8, "modelr");

    // Turbo X with strobe held: q1 tracks phase, 4 cycles per half-period
    joy1 = 12'hDFF;
    wr4016 = 1'b1; din0 = 1'b1;
    tick();
    wr4016 = 1'b0;
    rd4016 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push16(1'(((edges - 1) / 4) % 2), 1'(((edges - 1) / 4) % 2), $sformatf("turbo[%0d]", i));
      if (i < 15) tick();
    end
    tick();
    rd4016 = 1'b0; wr4016 = 1'b1; din0 = 1'b0;
    tick();
    wr4016 = 1'b0;

    // Latch 0x82 / 0x08, then press everything; reads show the latched bytes
    joy1 = 12'hF7E; joy2 = 12'hFF7;
    strobe_pulse();
    joy1 = 12'h000; joy2 = 12'h000;
    b1 = 8'h82; b2 = 8'h08;
    for (int i = 0; i < 4; i++) begin
      read16(b1[i], b1[i], $sformatf("latch16[%0d]", i));
      read17(b2[i], b2[i], $sformatf("latch17[%0d]", i));
    end
    for (int i = 4; i < 8; i++) read_both(b1[i], b2[i], $sformatf("both[%0d]", i));
    read_both(1'b1, 1'b1, "both_fill");

    // Write coinciding with read end: load 0x01, no shift of 0xC0
    joy1 = 12'hFFE; joy2 = 12'hFFF;
    strobe_pulse();
    read16(1'b0, 1'b0, "coll_pre0");
    read16(1'b1, 1'b1, "coll_pre1");
    joy1 = 12'hFFD;
    push16(1'b0, 1'b0, "coll_during");
    rd4016 = 1'b1;
    tick();
    rd4016 = 1'b0; wr4016 = 1'b1; din0 = 1'b0;
    tick();
    wr4016 = 1'b0;
    read16(1'b1, 1'b1, "coll_after0");
    read16(1'b0, 1'b0, "coll_after1");

    // Reset mid-sequence returns both ports to 00
    joy1 = 12'hFFD; joy2 = 12'hFFE;
    strobe_pulse();
    read16(1'b1, 1'b1, "midrst16_pre");
    read17(1'b0, 1'b0, "midrst17_pre");
    do_reset();
    read16(1'b0, 1'b0, "midrst16_post0");
    read16(1'b0, 1'b0, "midrst16_post1");
    read17(1'b0, 1'b0, "midrst17_post0");
    read17(1'b0, 1'b0, "midrst17_post1");

    // Every expected entry must have been consumed by the monitor
    for (int i = 0; i < 10 && (q16.size() != 0 || q17.size() != 0); i++) tick();
    checks++;
    if (q16.size() != 0 || q17.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q16.size(), q17.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
